pc_fetch_gen: RTL and testbench

Parametrised program-counter generator for the instruction-fetch stage. It holds the fetch PC and presents it to instruction memory through a valid/ready request handshake. It applies flush and branch redirects with fixed priority, and buffers a branch redirect that arrives during a pipeline stall so the redirect is not lost. It also reports fetch-address misalignment as an exception vector for the decode stage.

---
 rtl/pc_fetch_gen.sv | 127 ++++++++++++
 tb/tb_pc_fetch_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen -- program-counter generator for the instruction-fetch stage.
//
// Holds the fetch PC and offers it to instruction memory over a valid/ready
// request handshake. Redirects are applied with a fixed priority:
//   reset > flush > branch-while-stalled (buffered) > stall
//         > live branch > buffered branch > sequential increment.
// A branch that arrives while the pipeline is stalled is parked in a
// one-entry redirect buffer. It is replayed on the first unstalled cycle.
// A PC that is not word aligned is reported through excp[IADEL_BIT]. While
// it is misaligned, no request is issued.
//
// Parameters:
//   ADDR_W      width of the PC and all address ports
//   RESET_VEC   PC value loaded on reset
//   FETCH_BYTES sequential PC increment per accepted request (4 or 8)
//   EXC_W       width of the exception vector
//   IADEL_BIT   bit of excp that flags an instruction-address error
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   stall                hold the PC and present no request
//   flush, flush_pc      highest-priority redirect (exception / ERET)
//   br_taken, br_target  branch/jump redirect
//   req_valid, req_addr  fetch request to instruction memory
//   req_ready            instruction memory accepts the request
//   pc                   current fetch PC
//   excp                 exception vector (only IADEL_BIT is ever set)
//   pend_valid           a buffered branch redirect is waiting

module pc_fetch_gen #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = 32'hBFC0_0000,
  parameter int                FETCH_BYTES = 4,
  parameter int                EXC_W       = 32,
  parameter int                IADEL_BIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [EXC_W-1:0]  excp,
  output logic              pend_valid
);

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(FETCH_BYTES);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic misalign;
  logic fire;

  // Only the two low bits are checked, even when FETCH_BYTES is 8.
  // Sub-doubleword selection is handled by the memory side.
  assign misalign = (pc_q[1:0] != 2'b00);

  // req_valid depends only on state, rst and stall. It does not depend on
  // req_ready, so no combinational path runs from ready back to valid.
  assign req_valid = !rst && !stall && !pend_valid_q && !misalign;
  assign req_addr  = pc_q;
  assign pc        = pc_q;
  assign pend_valid = pend_valid_q;
  assign fire      = req_valid && req_ready;

  always_comb begin
    excp            = '0;
    excp[IADEL_BIT] = misalign;
  end

  // Next-state selection. The order of the branches encodes the redirect
  // priority. A request that fires in the same cycle as a redirect still
  // counts as issued. The redirect only replaces the increment.
  always_comb begin
    // NOTE: every signal written here gets a default first. Otherwise a path
    // that leaves a signal unassigned would infer a latch.
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;

    if (flush) begin
      // A same-cycle branch is dropped, and so is any pending one.
      pc_d         = flush_pc;
      pend_valid_d = 1'b0;
    end else if (stall && br_taken) begin
      // Park the branch. A newer branch overwrites an older pending one.
      pend_valid_d = 1'b1;
      pend_addr_d  = br_target;
    end else if (stall) begin
      // Hold everything.
    end else if (br_taken) begin
      // A live branch supersedes a buffered one.
      pc_d         = br_target;
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      pc_d         = pend_addr_q;
      pend_valid_d = 1'b0;
    end else if (fire) begin
      // Wraps modulo 2^ADDR_W.
      pc_d = pc_q + PC_INC;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VEC;
      pend_valid_q <= 1'b0;
      // NOTE: pend_addr is only read when pend_valid is set. It is reset anyway
      // so that the register never holds an undefined value.
      pend_addr_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen. Inputs change 1 time unit after each rising
// edge. Outputs are sampled on the falling edge.
//
// Each address that is expected to be accepted (req_valid & req_ready) is
// pushed onto exp_q when the stimulus is driven. A monitor pops and compares
// it when the handshake occurs on the 4-byte instance. A second instance with
// FETCH_BYTES=8 shares the inputs and is used for the wrap check.

module tb_pc_fetch_gen;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] RVEC   = 32'hBFC0_0000;

  logic              clk = 1'b0;
  logic              rst, stall, flush, br_taken, req_ready;
  logic [ADDR_W-1:0] flush_pc, br_target;

  logic              req_valid, pend_valid;
  logic [ADDR_W-1:0] req_addr, pc;
  logic [31:0]       excp;

  logic              req_valid8, pend_valid8;
  logic [ADDR_W-1:0] req_addr8, pc8;
  logic [31:0]       excp8;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pc_fetch_gen #(.FETCH_BYTES(4)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_taken(br_taken), .br_target(br_target), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(req_ready), .pc(pc), .excp(excp),
    .pend_valid(pend_valid)
  );

  pc_fetch_gen #(.FETCH_BYTES(8)) u_dut8 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_taken(br_taken), .br_target(br_target), .req_valid(req_valid8),
    .req_addr(req_addr8), .req_ready(req_ready), .pc(pc8), .excp(excp8),
    .pend_valid(pend_valid8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the n-th following rising edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard side: every accepted request must match the next expectation.
  always @(negedge clk) begin
    if (req_valid === 1'b1 && req_ready === 1'b1) begin
      check("fire_expected", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("fire_addr", req_addr, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; req_ready = 1'b0;
    flush_pc = '0; br_target = '0;

    // Reset, held for two edges.
    cycles(2);
    @(negedge clk);
    check("rst_pc", pc, RVEC);
    check("rst_valid", {31'b0, req_valid}, 32'd0);
    check("rst_pend", {31'b0, pend_valid}, 32'd0);
    check("rst_excp", excp, 32'd0);

    // Sequential fetch, with backpressure at BFC00008.
    cycles(1);
    rst = 1'b0; req_ready = 1'b1;
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hBFC0_0004);
    cycles(2);
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, req_valid}, 32'd1);
      check("bp_addr", req_addr, 32'hBFC0_0008);
      cycles(1);
    end
    req_ready = 1'b1;
    exp_q.push_back(32'hBFC0_0008);
    exp_q.push_back(32'hBFC0_000C);
    cycles(2);
    req_ready = 1'b0;
    @(negedge clk);
    check("seq_pc", pc, 32'hBFC0_0010);
    check("seq_excp", excp, 32'd0);

    // Branch during stall is buffered, then replayed.
    cycles(1);
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h8000_1000;
    cycles(1);
    br_taken = 1'b0;
    @(negedge clk);
    check("stl_pc_hold", pc, 32'hBFC0_0010);
    check("stl_pend", {31'b0, pend_valid}, 32'd1);
    check("stl_valid", {31'b0, req_valid}, 32'd0);
    cycles(1);
    @(negedge clk);
    check("stl_pend2", {31'b0, pend_valid}, 32'd1);
    cycles(1);
    stall = 1'b0; req_ready = 1'b1;
    exp_q.push_back(32'h8000_1000);
    @(negedge clk);
    check("unstl_valid", {31'b0, req_valid}, 32'd0);
    check("unstl_pend", {31'b0, pend_valid}, 32'd1);
    cycles(1);
    @(negedge clk);
    check("replay_addr", req_addr, 32'h8000_1000);
    check("replay_pend", {31'b0, pend_valid}, 32'd0);

    // Flush beats stall, branch and a pending buffer.
    cycles(1);
    req_ready = 1'b0; stall = 1'b1; br_taken = 1'b1; br_target = 32'h8000_3000;
    cycles(1);
    flush = 1'b1; flush_pc = 32'h8000_0180; br_target = 32'h8000_2000;
    @(negedge clk);
    check("prio_pend_set", {31'b0, pend_valid}, 32'd1);
    cycles(1);
    flush = 1'b0; br_taken = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("prio_pc", pc, 32'h8000_0180);
    check("prio_pend", {31'b0, pend_valid}, 32'd0);
    check("prio_valid", {31'b0, req_valid}, 32'd1);

    // Misaligned branch target: no request and no advance until flushed.
    cycles(1);
    br_taken = 1'b1; br_target = 32'h8000_0002;
    cycles(1);
    br_taken = 1'b0; req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mis_excp", excp, 32'h0000_0010);
      check("mis_valid", {31'b0, req_valid}, 32'd0);
      check("mis_pc", pc, 32'h8000_0002);
      cycles(1);
    end
    flush = 1'b1; flush_pc = 32'h8000_0180;
    cycles(1);
    flush = 1'b0; req_ready = 1'b0;
    @(negedge clk);
    check("mis_clr_excp", excp, 32'd0);
    check("mis_clr_pc", pc, 32'h8000_0180);
    check("mis_clr_valid", {31'b0, req_valid}, 32'd1);

    // Reset during a stall with a branch pending clears everything.
    cycles(1);
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h8000_4000;
    cycles(1);
    br_taken = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pend", {31'b0, pend_valid}, 32'd1);
    check("rst_mid_valid", {31'b0, req_valid}, 32'd0);
    cycles(1);
    rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("rst_mid_pc", pc, RVEC);
    check("rst_mid_pend0", {31'b0, pend_valid}, 32'd0);

    // Wrap at the top of the address space (both increment sizes).
    cycles(1);
    br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
    cycles(1);
    br_taken = 1'b0; req_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    cycles(1);
    @(negedge clk);
    check("wrap8_pc", pc8, 32'h0000_0000);
    check("wrap8_excp", excp8, 32'd0);
    check("inc4_pc", pc, 32'hFFFF_FFFC);
    cycles(1);
    req_ready = 1'b0;
    @(negedge clk);
    check("wrap4_pc", pc, 32'h0000_0000);
    check("inc8_pc", pc8, 32'h0000_0008);

    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
